up_counter_cmp: RTL and testbench

- Loadable up-counter with compare; the counting counterpart of the team's loadable down-counter.
- Counts from 0 up to a latched limit, then pulses done. Optionally restarts automatically.
- Used as an elapsed-cycle or interval generator alongside the down-counter datapath blocks (adder, register).
- Single clock domain; all state is updated on the rising edge of clk.

---
 rtl/up_counter_cmp_if.sv | 23 ++
 rtl/up_counter_cmp.sv | 85 ++++++++
 tb/tb_up_counter_cmp.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/up_counter_cmp_if.sv
// rtl/up_counter_cmp_if.sv - control and status bundle for the loadable up-counter
interface up_counter_cmp_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             restart_err;

  modport master (
    output start, stop, auto_reload, limit,
    input  q, busy, done, restart_err
  );

  modport slave (
    input  start, stop, auto_reload, limit,
    output q, busy, done, restart_err
  );
endinterface

// File: rtl/up_counter_cmp.sv
// rtl/up_counter_cmp.sv - up-counter that counts 0..latched limit, pulses done, optional auto reload
module up_counter_cmp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  up_counter_cmp_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [WIDTH-1:0] lim_r, lim_nxt;
  logic             busy_r;
  logic             done_r, done_nxt;
  logic             err_r, err_nxt;
  logic             match;

  assign match = (q_r == lim_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      q_r    <= '0;
      lim_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_r    <= q_nxt;
      lim_r  <= lim_nxt;
      busy_r <= (state_nxt == RUN);
      done_r <= done_nxt;
      err_r  <= err_nxt;
    end
  end

  // A zero limit completes immediately, so it never enters RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start && (bus.limit != '0)) state_nxt = RUN;
      RUN: begin
        if (bus.stop)                       state_nxt = IDLE;
        else if (match && !bus.auto_reload) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_nxt    = q_r;
    lim_nxt  = lim_r;
    done_nxt = 1'b0;
    err_nxt  = err_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          lim_nxt  = bus.limit;
          q_nxt    = '0;
          done_nxt = (bus.limit == '0);
        end
      end
      RUN: begin
        // stop outranks both the restart flag and a simultaneous match
        if (!bus.stop) begin
          if (bus.start) err_nxt = 1'b1;
          if (match) begin
            done_nxt = 1'b1;
            if (bus.auto_reload) q_nxt = '0;
          end else begin
            q_nxt = q_r + WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.q           = q_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.restart_err = err_r;
endmodule

// File: tb/tb_up_counter_cmp.sv
// tb/tb_up_counter_cmp.sv - vector table, corner sequences and random model check for up_counter_cmp
module tb_up_counter_cmp;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  up_counter_cmp_if #(.WIDTH(4)) bus();

  up_counter_cmp #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic       ar;
    logic [3:0] limit;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  // reference model: integer count against the latched limit
  bit m_run;
  int m_q, m_lim;
  bit m_done, m_err;

  function automatic vec_t mk(input logic rst, st, sp, ar, input logic [3:0] lim,
                              input logic [3:0] eq, input logic eb, ed, ee);
    vec_t v;
    v.rst = rst; v.start = st; v.stop = sp; v.ar = ar; v.limit = lim;
    v.q = eq; v.busy = eb; v.done = ed; v.err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic apply(input logic rst, st, sp, ar, input logic [3:0] lim);
    reset = rst; bus.start = st; bus.stop = sp; bus.auto_reload = ar; bus.limit = lim;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic rst, st, sp, ar, input int lim);
    if (rst) begin
      m_run = 0; m_q = 0; m_lim = 0; m_done = 0; m_err = 0;
      return;
    end
    m_done = 0;
    if (!m_run) begin
      if (st) begin
        m_lim = lim;
        m_q = 0;
        if (lim == 0) m_done = 1;
        else m_run = 1;
      end
    end else if (sp) begin
      m_run = 0;
    end else begin
      if (st) m_err = 1;
      if (m_q == m_lim) begin
        m_done = 1;
        if (ar) m_q = 0;
        else m_run = 0;
      end else begin
        m_q = m_q + 1;
      end
    end
  endtask

  initial begin
    reset = 1'b1; bus.start = 0; bus.stop = 0; bus.auto_reload = 0; bus.limit = 0;

    // reset state
    vecs.push_back(mk(1,0,0,0,4'd0,  4'd0,0,0,0));
    // basic count, limit=5; limit bus changes are ignored while running
    vecs.push_back(mk(0,1,0,0,4'd5,  4'd0,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd9,  4'd1,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd9,  4'd2,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd9,  4'd3,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd9,  4'd4,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd9,  4'd5,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd9,  4'd5,0,1,0));
    vecs.push_back(mk(0,0,1,0,4'd9,  4'd5,0,0,0));
    // stop colliding with a match
    vecs.push_back(mk(0,1,0,0,4'd2,  4'd0,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd2,  4'd1,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd2,  4'd2,1,0,0));
    vecs.push_back(mk(0,0,1,0,4'd2,  4'd2,0,0,0));
    vecs.push_back(mk(0,0,0,0,4'd2,  4'd2,0,0,0));
    // zero limit finishes without going busy
    vecs.push_back(mk(0,1,0,0,4'd0,  4'd0,0,1,0));
    vecs.push_back(mk(0,0,0,0,4'd0,  4'd0,0,0,0));
    // restart while running: flag is sticky, new limit ignored
    vecs.push_back(mk(0,1,0,0,4'd6,  4'd0,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd6,  4'd1,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd6,  4'd2,1,0,0));
    vecs.push_back(mk(0,0,0,0,4'd6,  4'd3,1,0,0));
    vecs.push_back(mk(0,1,0,0,4'd1,  4'd4,1,0,1));
    vecs.push_back(mk(0,0,0,0,4'd1,  4'd5,1,0,1));
    vecs.push_back(mk(0,0,0,0,4'd1,  4'd6,1,0,1));
    vecs.push_back(mk(0,0,0,0,4'd1,  4'd6,0,1,1));
    vecs.push_back(mk(0,0,0,0,4'd1,  4'd6,0,0,1));
    // reset with start held after a run
    vecs.push_back(mk(1,1,0,0,4'd5,  4'd0,0,0,0));
    vecs.push_back(mk(0,0,0,0,4'd5,  4'd0,0,0,0));
    // auto reload, limit=3, then stop freezes q
    vecs.push_back(mk(0,1,0,1,4'd3,  4'd0,1,0,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd1,1,0,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd2,1,0,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd3,1,0,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd0,1,1,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd1,1,0,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd2,1,0,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd3,1,0,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd0,1,1,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd1,1,0,0));
    vecs.push_back(mk(0,0,1,1,4'd3,  4'd1,0,0,0));
    vecs.push_back(mk(0,0,0,1,4'd3,  4'd1,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].ar, vecs[i].limit);
      chk($sformatf("vec%0d_q", i),    bus.q,           vecs[i].q);
      chk($sformatf("vec%0d_busy", i), bus.busy,        vecs[i].busy);
      chk($sformatf("vec%0d_done", i), bus.done,        vecs[i].done);
      chk($sformatf("vec%0d_err", i),  bus.restart_err, vecs[i].err);
    end

    // maximum limit counts through all ones without wrapping
    apply(0,1,0,0,4'd15);
    chk("max_q0", bus.q, 0);
    chk("max_busy0", bus.busy, 1);
    for (int i = 1; i <= 15; i++) begin
      apply(0,0,0,0,4'd0);
      chk($sformatf("max_q%0d", i), bus.q, i);
      chk($sformatf("max_busy%0d", i), bus.busy, 1);
      chk($sformatf("max_done%0d", i), bus.done, 0);
    end
    apply(0,0,0,0,4'd0);
    chk("max_end_q", bus.q, 15);
    chk("max_end_busy", bus.busy, 0);
    chk("max_end_done", bus.done, 1);

    // randomized run against the model
    apply(1,0,0,0,4'd0);
    model_step(1,0,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_st, r_sp, r_ar;
      logic [3:0] r_lim;
      r_rst = ($urandom_range(0,99) == 0);
      r_st  = ($urandom_range(0,7) == 0);
      r_sp  = ($urandom_range(0,19) == 0);
      r_ar  = ($urandom_range(0,2) != 0);
      r_lim = 4'($urandom_range(0,15));
      apply(r_rst, r_st, r_sp, r_ar, r_lim);
      model_step(r_rst, r_st, r_sp, r_ar, int'(r_lim));
      chk("rand_q",    bus.q,           m_q);
      chk("rand_busy", bus.busy,        m_run);
      chk("rand_done", bus.done,        m_done);
      chk("rand_err",  bus.restart_err, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
